// File: rtl/rs485_uart_tx_if.sv
// Producer-side bundle for the RS-485 UART transmitter: byte handshake plus line/direction pins.
// A byte moves on a rising edge where tx_valid and tx_ready are both high; tx_data is held stable with tx_valid.
interface rs485_uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 txd;
    logic                 de;
    logic                 re_n;
    logic                 busy;

    modport master (output tx_data, tx_valid, input tx_ready, txd, de, re_n, busy);
    modport slave  (input tx_data, tx_valid, output tx_ready, txd, de, re_n, busy);
endinterface

// File: rtl/rs485_uart_tx.sv
// UART transmitter for an RS-485 transceiver: frames one byte per handshake and wraps the frame
// in DE guard time; all outputs are registered from the next-state decode.
module rs485_uart_tx #(
    parameter int CLKS_PER_BIT = 2604,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1,
    parameter int GUARD_CLKS   = 2604
) (
    input  logic           clk,
    input  logic           rst_n,
    rs485_uart_tx_if.slave bus,
    output logic [2:0]     state_dbg
);
    localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
    localparam int MAX_CLKS  = (STOP_CLKS > GUARD_CLKS) ? STOP_CLKS : GUARD_CLKS;
    localparam int CW        = $clog2(MAX_CLKS + 1);
    localparam int IW        = $clog2(DATA_BITS);

    localparam logic [CW-1:0] BIT_LOAD   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_LOAD  = CW'(STOP_CLKS - 1);
    localparam logic [CW-1:0] GUARD_LOAD = CW'((GUARD_CLKS > 0) ? GUARD_CLKS - 1 : 0);
    localparam logic [IW-1:0] LAST_IDX   = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEAD   = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5,
        S_TAIL   = 3'd6
    } state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [IW-1:0]        idx, idx_n;
    logic [DATA_BITS-1:0] data_q, data_n;
    logic                 txd_q, txd_n;
    logic                 de_q, de_n;
    logic                 ready_q, ready_n;
    logic                 busy_q, busy_n;
    logic                 handshake;
    logic                 last;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = idx;
        data_n    = data_q;
        handshake = bus.tx_valid && ready_q;
        last      = (cnt == '0);

        case (state)
            S_IDLE: begin
                if (handshake) begin
                    data_n = bus.tx_data;
                    if (GUARD_CLKS > 0) begin
                        state_n = S_LEAD;
                        cnt_n   = GUARD_LOAD;
                    end else begin
                        state_n = S_START;
                        cnt_n   = BIT_LOAD;
                    end
                end
            end
            S_LEAD: begin
                if (last) begin
                    state_n = S_START;
                    cnt_n   = BIT_LOAD;
                end else cnt_n = cnt - CW'(1);
            end
            S_START: begin
                if (last) begin
                    state_n = S_DATA;
                    idx_n   = '0;
                    cnt_n   = BIT_LOAD;
                end else cnt_n = cnt - CW'(1);
            end
            S_DATA: begin
                if (!last) cnt_n = cnt - CW'(1);
                else if (idx != LAST_IDX) begin
                    idx_n = idx + IW'(1);
                    cnt_n = BIT_LOAD;
                end else if (PARITY_EN != 0) begin
                    state_n = S_PARITY;
                    cnt_n   = BIT_LOAD;
                end else begin
                    state_n = S_STOP;
                    cnt_n   = STOP_LOAD;
                end
            end
            S_PARITY: begin
                if (last) begin
                    state_n = S_STOP;
                    cnt_n   = STOP_LOAD;
                end else cnt_n = cnt - CW'(1);
            end
            S_STOP: begin
                // tx_ready is only high in the final stop cycle, so a handshake here chains frames.
                if (handshake) begin
                    data_n  = bus.tx_data;
                    state_n = S_START;
                    cnt_n   = BIT_LOAD;
                end else if (!last) cnt_n = cnt - CW'(1);
                else if (GUARD_CLKS > 0) begin
                    state_n = S_TAIL;
                    cnt_n   = GUARD_LOAD;
                end else state_n = S_IDLE;
            end
            S_TAIL: begin
                if (last) state_n = S_IDLE;
                else cnt_n = cnt - CW'(1);
            end
            default: state_n = S_IDLE;
        endcase

        txd_n = 1'b1;
        case (state_n)
            S_START:  txd_n = 1'b0;
            S_DATA:   txd_n = data_n[idx_n];
            S_PARITY: txd_n = (^data_n) ^ (PARITY_ODD != 0);
            default:  txd_n = 1'b1;
        endcase
        de_n    = (state_n != S_IDLE);
        busy_n  = (state_n != S_IDLE);
        ready_n = (state_n == S_IDLE) || ((state_n == S_STOP) && (cnt_n == '0));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            idx     <= '0;
            data_q  <= '0;
            txd_q   <= 1'b1;
            de_q    <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            data_q  <= data_n;
            txd_q   <= txd_n;
            de_q    <= de_n;
            ready_q <= ready_n;
            busy_q  <= busy_n;
        end
    end

    // The receiver is enabled exactly when the driver is off.
    assign bus.txd      = txd_q;
    assign bus.de       = de_q;
    assign bus.re_n     = de_q;
    assign bus.tx_ready = ready_q;
    assign bus.busy     = busy_q;
    assign state_dbg    = state;
endmodule

// File: tb/tb_rs485_uart_tx.sv
// Directed bench for rs485_uart_tx: frame waveforms, guard time, chaining, parity and reset recovery.
module tb_rs485_uart_tx;
    localparam int CPB   = 4;
    localparam int GUARD = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic [2:0] st_main, st_even, st_odd;
    int vectors = 0;
    int miscompares = 0;

    // Expected per-cycle {txd, de, tx_ready}; busy and re_n must track de.
    logic [2:0] exp_q[$];
    logic [2:0] exp_even_q[$];
    logic [2:0] exp_odd_q[$];

    rs485_uart_tx_if #(.DATA_BITS(8)) bus();
    rs485_uart_tx_if #(.DATA_BITS(8)) pe();
    rs485_uart_tx_if #(.DATA_BITS(8)) po();

    rs485_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                    .STOP_BITS(1), .GUARD_CLKS(GUARD))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus), .state_dbg(st_main));
    rs485_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
                    .STOP_BITS(1), .GUARD_CLKS(GUARD))
        dut_even (.clk(clk), .rst_n(rst_n), .bus(pe), .state_dbg(st_even));
    rs485_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1),
                    .STOP_BITS(1), .GUARD_CLKS(GUARD))
        dut_odd (.clk(clk), .rst_n(rst_n), .bus(po), .state_dbg(st_odd));

    always #5 clk = ~clk;

    task automatic push_exp(input int sel, input logic [2:0] e);
        case (sel)
            1:       exp_even_q.push_back(e);
            2:       exp_odd_q.push_back(e);
            default: exp_q.push_back(e);
        endcase
    endtask

    // Reference frame: optional lead guard, start, LSB-first data, optional parity, one stop, optional tail.
    task automatic model_frame(input int sel, input logic [7:0] d, input bit lead, input bit tail,
                               input bit par_en, input bit par_odd);
        logic lvl[$];
        logic rdy;
        lvl.push_back(1'b0);
        for (int b = 0; b < 8; b++) lvl.push_back(d[b]);
        if (par_en) lvl.push_back((^d) ^ par_odd);
        lvl.push_back(1'b1);
        if (lead) for (int g = 0; g < GUARD; g++) push_exp(sel, 3'b110);
        for (int b = 0; b < lvl.size(); b++)
            for (int c = 0; c < CPB; c++) begin
                rdy = (b == lvl.size() - 1) && (c == CPB - 1);
                push_exp(sel, {lvl[b], 1'b1, rdy});
            end
        if (tail) begin
            for (int g = 0; g < GUARD; g++) push_exp(sel, 3'b110);
            for (int g = 0; g < 2; g++) push_exp(sel, 3'b101);
        end
    endtask

    task automatic test_reset();
        logic [4:0] obs;
        rst_n = 1'b0;
        bus.tx_valid = 1'b1; bus.tx_data = 8'hA5;
        pe.tx_valid = 1'b0;  pe.tx_data = 8'h00;
        po.tx_valid = 1'b0;  po.tx_data = 8'h00;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (i == 2) begin
                bus.tx_valid = 1'b0;
                rst_n = 1'b1;
            end
            obs = {bus.txd, bus.de, bus.re_n, bus.tx_ready, bus.busy};
            vectors++;
            if (obs !== 5'b10010) begin
                miscompares++;
                $display("FAIL reset cycle %0d: {txd,de,re_n,rdy,busy} got %b want 10010", i, obs);
            end
            vectors++;
            if (st_main !== 3'd0) begin
                miscompares++;
                $display("FAIL reset_state cycle %0d: got %0d want 0", i, st_main);
            end
        end
    endtask

    task automatic test_single();
        logic [4:0] obs;
        logic [2:0] e;
        int i = 0;
        int de_cnt = 0;
        model_frame(0, 8'hA5, 1, 1, 0, 0);
        bus.tx_data = 8'hA5; bus.tx_valid = 1'b1;
        @(posedge clk); #1;
        bus.tx_valid = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            obs = {bus.txd, bus.de, bus.re_n, bus.tx_ready, bus.busy};
            de_cnt += int'(bus.de);
            vectors++;
            if (obs !== {e[2], e[1], e[1], e[0], e[1]}) begin
                miscompares++;
                $display("FAIL single_a5 cycle %0d: got %b want %b", i, obs, {e[2], e[1], e[1], e[0], e[1]});
            end
            i++;
            @(posedge clk); #1;
        end
        vectors++;
        if (de_cnt != 44) begin
            miscompares++;
            $display("FAIL single_de_len: got %0d want 44", de_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] obs;
        logic [2:0] e;
        int i = 0;
        int de_cnt = 0;
        model_frame(0, 8'h00, 1, 0, 0, 0);
        model_frame(0, 8'hFF, 0, 1, 0, 0);
        bus.tx_data = 8'h00; bus.tx_valid = 1'b1;
        @(posedge clk); #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            obs = {bus.txd, bus.de, bus.re_n, bus.tx_ready, bus.busy};
            de_cnt += int'(bus.de);
            vectors++;
            if (obs !== {e[2], e[1], e[1], e[0], e[1]}) begin
                miscompares++;
                $display("FAIL b2b cycle %0d: got %b want %b", i, obs, {e[2], e[1], e[1], e[0], e[1]});
            end
            if (i == 0) bus.tx_data = 8'hFF;
            if (i == 42) bus.tx_valid = 1'b0;
            i++;
            @(posedge clk); #1;
        end
        vectors++;
        if (de_cnt != 84) begin
            miscompares++;
            $display("FAIL b2b_de_len: got %0d want 84", de_cnt);
        end
    endtask

    task automatic test_parity();
        logic [4:0] obs;
        logic [2:0] e;
        int i = 0;
        int de_cnt = 0;
        model_frame(1, 8'h07, 1, 1, 1, 0);
        model_frame(2, 8'h07, 1, 1, 1, 1);
        pe.tx_data = 8'h07; pe.tx_valid = 1'b1;
        po.tx_data = 8'h07; po.tx_valid = 1'b1;
        @(posedge clk); #1;
        pe.tx_valid = 1'b0; po.tx_valid = 1'b0;
        while (exp_even_q.size() > 0 && exp_odd_q.size() > 0) begin
            e = exp_even_q.pop_front();
            obs = {pe.txd, pe.de, pe.re_n, pe.tx_ready, pe.busy};
            de_cnt += int'(pe.de);
            vectors++;
            if (obs !== {e[2], e[1], e[1], e[0], e[1]}) begin
                miscompares++;
                $display("FAIL parity_even cycle %0d: got %b want %b", i, obs, {e[2], e[1], e[1], e[0], e[1]});
            end
            e = exp_odd_q.pop_front();
            obs = {po.txd, po.de, po.re_n, po.tx_ready, po.busy};
            vectors++;
            if (obs !== {e[2], e[1], e[1], e[0], e[1]}) begin
                miscompares++;
                $display("FAIL parity_odd cycle %0d: got %b want %b", i, obs, {e[2], e[1], e[1], e[0], e[1]});
            end
            if (i == GUARD + 9 * CPB + 1) begin
                vectors++;
                if ({pe.txd, po.txd} !== 2'b10) begin
                    miscompares++;
                    $display("FAIL parity_bit: {even,odd} got %b want 10", {pe.txd, po.txd});
                end
            end
            i++;
            @(posedge clk); #1;
        end
        vectors++;
        if (de_cnt != 48) begin
            miscompares++;
            $display("FAIL parity_de_len: got %0d want 48", de_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [4:0] obs;
        logic [2:0] e;
        int i = 0;
        model_frame(0, 8'h5A, 1, 1, 0, 0);
        bus.tx_data = 8'h5A; bus.tx_valid = 1'b1;
        @(posedge clk); #1;
        bus.tx_valid = 1'b0;
        while (i <= 18) begin
            e = exp_q.pop_front();
            obs = {bus.txd, bus.de, bus.re_n, bus.tx_ready, bus.busy};
            vectors++;
            if (obs !== {e[2], e[1], e[1], e[0], e[1]}) begin
                miscompares++;
                $display("FAIL pre_reset cycle %0d: got %b want %b", i, obs, {e[2], e[1], e[1], e[0], e[1]});
            end
            if (i == 18) rst_n = 1'b0;
            i++;
            @(posedge clk); #1;
        end
        exp_q.delete();
        rst_n = 1'b1;
        obs = {bus.txd, bus.de, bus.re_n, bus.tx_ready, bus.busy};
        vectors++;
        if (obs !== 5'b10010) begin
            miscompares++;
            $display("FAIL mid_reset: got %b want 10010", obs);
        end
        @(posedge clk); #1;
        vectors++;
        if (st_main !== 3'd0) begin
            miscompares++;
            $display("FAIL mid_reset_state: got %0d want 0", st_main);
        end
        model_frame(0, 8'h3C, 1, 1, 0, 0);
        bus.tx_data = 8'h3C; bus.tx_valid = 1'b1;
        @(posedge clk); #1;
        bus.tx_valid = 1'b0;
        i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            obs = {bus.txd, bus.de, bus.re_n, bus.tx_ready, bus.busy};
            vectors++;
            if (obs !== {e[2], e[1], e[1], e[0], e[1]}) begin
                miscompares++;
                $display("FAIL post_reset_3c cycle %0d: got %b want %b", i, obs, {e[2], e[1], e[1], e[0], e[1]});
            end
            i++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_busy_hold();
        logic [4:0] obs;
        logic [2:0] e;
        int i = 0;
        model_frame(0, 8'h81, 1, 0, 0, 0);
        model_frame(0, 8'hFF, 0, 1, 0, 0);
        bus.tx_data = 8'h81; bus.tx_valid = 1'b1;
        @(posedge clk); #1;
        bus.tx_valid = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            obs = {bus.txd, bus.de, bus.re_n, bus.tx_ready, bus.busy};
            vectors++;
            if (obs !== {e[2], e[1], e[1], e[0], e[1]}) begin
                miscompares++;
                $display("FAIL busy_hold cycle %0d: got %b want %b", i, obs, {e[2], e[1], e[1], e[0], e[1]});
            end
            if (i == 5) begin
                bus.tx_data = 8'hFF;
                bus.tx_valid = 1'b1;
            end
            if (i == 42) bus.tx_valid = 1'b0;
            i++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_reset_mid_frame();
        test_busy_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
